bus_unpacker: RTL

Receive-side counterpart of the supplier packer: accepts 32-bit packed bus words (four 8-bit buckets, lane 0 in bits [7:0]) and re-expands each word into a stream of 21-bit items, one bucket per item. Each item is tagged with its lane index in bits [11:8], the same field the packer sorts on. Sits between the NoC bus and the per-item consumer. Buffers up to FIFO_DEPTH words and applies valid/ready backpressure on both sides.

---
 rtl/bus_unpacker.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bus_unpacker.sv
// bus_unpacker: buffers 32-bit packed bus words and re-expands each word into
// a stream of 21-bit items, one per (optionally non-zero) byte lane, tagged
// with lane index, last-of-word flag and a per-word sequence number.
module bus_unpacker #(
  parameter int DATA_SIZE  = 32,
  parameter int OUT_SIZE   = 21,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_SIZE-1:0]          in_data,
  input  logic                          skip_zero,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_SIZE-1:0]           out_data,
  output logic                          buf_empty,
  output logic                          buf_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_counter
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, EMIT} state_t;

  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;

  state_t      state;
  logic [31:0] word_reg;
  logic [3:0]  lane_mask;   // lanes of word_reg still to be emitted, incl. current
  logic [7:0]  seq;         // number to assign to the next popped word
  logic [7:0]  word_seq;    // number assigned to the word in word_reg

  logic        push, pop, handshake, word_done;
  logic [1:0]  cur_lane;
  logic [3:0]  rem_mask;
  logic [31:0] head;
  logic [3:0]  head_mask;

  // Lowest set bit of a 4-bit lane mask.
  function automatic logic [1:0] lowest(input logic [3:0] m);
    casez (m)
      4'b???1: return 2'd0;
      4'b??10: return 2'd1;
      4'b?100: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Item for the lowest set lane of m: {seq, last, lane, byte}.
  function automatic logic [20:0] make_item(input logic [31:0] w,
                                            input logic [3:0]  m,
                                            input logic [7:0]  sq);
    logic [1:0] l;
    logic [3:0] rest;
    l    = lowest(m);
    rest = m & ~(4'b0001 << l);
    return {sq, (rest == 4'd0), {2'b00, l}, w[8*l +: 8]};
  endfunction

  assign buf_empty = (fifo_counter == '0);
  assign buf_full  = (fifo_counter == CW'(FIFO_DEPTH));
  assign in_ready  = !buf_full;
  assign push      = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  assign cur_lane  = lowest(lane_mask);
  assign rem_mask  = lane_mask & ~(4'b0001 << cur_lane);
  // The unpack stage is free for a new word when idle, or when the last lane
  // of the current word is accepted this cycle (no-bubble reload).
  assign word_done = (state == IDLE) || (handshake && (rem_mask == 4'd0));
  assign pop       = word_done && !buf_empty;
  assign head      = mem[rd_ptr][31:0];

  // Lanes to emit for the word at the buffer head; skip_zero applies at pop.
  always_comb begin
    head_mask = 4'b1111;
    if (skip_zero) begin
      for (int k = 0; k < 4; k++) head_mask[k] = (head[8*k +: 8] != 8'h00);
    end
  end

  // Buffer storage: contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_counter <= fifo_counter + CW'(1);
        2'b01:   fifo_counter <= fifo_counter - CW'(1);
        default: fifo_counter <= fifo_counter;
      endcase
    end
  end

  // Unpack FSM with registered item output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      word_reg  <= '0;
      lane_mask <= '0;
      seq       <= '0;
      word_seq  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop) begin
      // All-zero words under skip_zero still consume a sequence number.
      seq       <= seq + 8'd1;
      word_seq  <= seq;
      word_reg  <= head;
      lane_mask <= head_mask;
      if (head_mask != 4'd0) begin
        state     <= EMIT;
        out_valid <= 1'b1;
        out_data  <= OUT_SIZE'(make_item(head, head_mask, seq));
      end else begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end else if (state == EMIT && handshake) begin
      if (rem_mask != 4'd0) begin
        lane_mask <= rem_mask;
        out_data  <= OUT_SIZE'(make_item(word_reg, rem_mask, word_seq));
      end else begin
        state     <= IDLE;
        lane_mask <= '0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule
